// File: rtl/aqp_uart_rx_fifo.sv
// aqp_uart_rx_fifo: mid-bit sampling UART receiver feeding a show-ahead FIFO, with sticky error flags.
// Define AQP_UART_RX_BREAK_DETECT_EN to add the sticky break_detect output.
module aqp_uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 6,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          uart_rxd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          framing_error,
  output logic                          parity_error,
  output logic                          overflow,
`ifdef AQP_UART_RX_BREAK_DETECT_EN
  output logic                          break_detect,
`endif
  input  logic                          clear_errors
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK_WAIT} state_t;

  state_t                r_state;
  logic                  r_sync1, r_sync2, r_hist;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_pbit;
  logic                  r_commit;
  logic [AW:0]           r_wptr, r_rptr;
  logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
`ifdef AQP_UART_RX_BREAK_DETECT_EN
  logic                  r_all_low;
`endif

  logic        w_fall, w_samp, w_perr, w_empty, w_full, w_pop, w_push;
  logic [AW:0] w_level;

  always_comb begin
    w_fall     = r_hist & ~r_sync2;
    w_samp     = r_cnt == HALF;
    w_perr     = (PARITY == 1) ? ~(^r_shift ^ r_pbit) : (PARITY == 2) ? (^r_shift ^ r_pbit) : 1'b0;
    w_level    = r_wptr - r_rptr;
    w_empty    = w_level == '0;
    w_full     = w_level == FULL_LVL;
    w_pop      = ~w_empty & rx_ready;
    w_push     = r_commit & (~w_full | w_pop);
    rx_valid   = ~w_empty;
    fifo_level = w_level;
    rx_data    = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  end

  // The committed word stays in r_shift until the next frame's first data sample, so it is written from there.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr[AW-1:0]] <= r_shift;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state       <= IDLE;
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_hist        <= 1'b1;
      r_cnt         <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_pbit        <= 1'b0;
      r_commit      <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      overflow      <= 1'b0;
`ifdef AQP_UART_RX_BREAK_DETECT_EN
      r_all_low     <= 1'b0;
      break_detect  <= 1'b0;
`endif
    end else begin
      r_sync1  <= uart_rxd;
      r_sync2  <= r_sync1;
      r_hist   <= r_sync2;
      r_cnt    <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      r_commit <= 1'b0;
      // Clears come first so that a set later in this block wins the same cycle.
      if (clear_errors) begin
        framing_error <= 1'b0;
        parity_error  <= 1'b0;
        overflow      <= 1'b0;
`ifdef AQP_UART_RX_BREAK_DETECT_EN
        break_detect  <= 1'b0;
`endif
      end
      case (r_state)
        IDLE: if (w_fall) begin
          r_state <= START;
          r_cnt   <= '0;
`ifdef AQP_UART_RX_BREAK_DETECT_EN
          r_all_low <= 1'b1;
`endif
        end
        START: if (w_samp) begin
          r_state <= r_sync2 ? IDLE : DATA;
          r_bit   <= '0;
        end
        DATA: if (w_samp) begin
          r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
          r_bit   <= r_bit + 1'b1;
`ifdef AQP_UART_RX_BREAK_DETECT_EN
          r_all_low <= r_all_low & ~r_sync2;
`endif
          if (r_bit == LAST_BIT) r_state <= (PARITY != 0) ? PAR : STOP;
        end
        PAR: if (w_samp) begin
          r_pbit  <= r_sync2;
          r_state <= STOP;
`ifdef AQP_UART_RX_BREAK_DETECT_EN
          r_all_low <= r_all_low & ~r_sync2;
`endif
        end
        STOP: if (w_samp) begin
          if (r_sync2) begin
            r_state <= IDLE;
            if (w_perr) parity_error <= 1'b1;
            else r_commit <= 1'b1;
          end else begin
            r_state       <= BREAK_WAIT;
            framing_error <= 1'b1;
`ifdef AQP_UART_RX_BREAK_DETECT_EN
            if (r_all_low) break_detect <= 1'b1;
`endif
          end
        end
        BREAK_WAIT: if (r_sync2) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_push) r_wptr <= r_wptr + 1'b1;
      else if (r_commit) overflow <= 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
endmodule
